// File: rtl/stream_crypt_pkg.sv
// ==========================================================================
// stream_crypt_pkg: shared state encoding and FIFO sizing helper. Rev 1.0
// ==========================================================================
`default_nettype none

package stream_crypt_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_INIT = 2'd1,
    DROP      = 2'd2,
    RUN       = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stream_crypt_if.sv
// ==========================================================================
// stream_crypt_if: keystream, input and output handshakes. Rev 1.0
// ==========================================================================
`default_nettype none

interface stream_crypt_if #(
  parameter int W = 8
);
  logic         ks_valid;
  logic [W-1:0] ks_data;
  logic         ks_ready;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
`ifdef STREAM_CRYPT_BYPASS_EN
  logic         bypass;

  modport slave (
    input  ks_valid, ks_data, in_valid, in_data, out_ready, bypass,
    output ks_ready, in_ready, out_valid, out_data
  );
  modport master (
    output ks_valid, ks_data, in_valid, in_data, out_ready, bypass,
    input  ks_ready, in_ready, out_valid, out_data
  );
`else
  modport slave (
    input  ks_valid, ks_data, in_valid, in_data, out_ready,
    output ks_ready, in_ready, out_valid, out_data
  );
  modport master (
    output ks_valid, ks_data, in_valid, in_data, out_ready,
    input  ks_ready, in_ready, out_valid, out_data
  );
`endif
endinterface

`default_nettype wire

// File: rtl/stream_crypt_ks_fifo.sv
// ==========================================================================
// ks_fifo: first-word fall-through keystream FIFO with flush. Rev 1.0
// ==========================================================================
`default_nettype none

module ks_fifo
  import stream_crypt_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int PW   = clog2(DEPTH)
) (
  input  wire           clk,
  input  wire           rst,
  input  wire           push,
  input  wire           pop,
  input  wire           flush,
  input  wire  [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [PW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/stream_crypt.sv
// ==========================================================================
// stream_crypt: RC4-drop keystream buffer + XOR stage, registered output.
// Optional STREAM_CRYPT_BYPASS_EN adds a per-word plaintext bypass. Rev 1.0
// ==========================================================================
`default_nettype none

module stream_crypt
  import stream_crypt_pkg::*;
#(
  parameter int W      = 8,
  parameter int DEPTH  = 4,
  parameter int DROP_N = 0,
  parameter int CNT_W  = 16,
  localparam int PW    = clog2(DEPTH)
) (
  input  wire              clk,
  input  wire              rst,
  input  wire              start,
  input  wire              gen_init_done,
  stream_crypt_if.slave    bus,
  output logic             busy,
  output logic [CNT_W-1:0] word_cnt
);

  state_t       state;
  state_t       next_state;
  logic [7:0]   drop_cnt;
  logic         drop_last;
  logic         ks_rdy;
  logic         in_rdy;
  logic         ks_hs;
  logic         in_hs;
  logic         byp;
  logic         push;
  logic         pop;
  logic         flush;
  logic         out_valid_q;
  logic [W-1:0] out_data_q;
  logic [W-1:0] fifo_dout;
  logic [PW:0]  fifo_count;
  logic         fifo_full;
  logic         fifo_empty;

`ifdef STREAM_CRYPT_BYPASS_EN
  assign byp = bus.bypass;
`else
  assign byp = 1'b0;
`endif

  assign ks_hs     = bus.ks_valid && ks_rdy;
  assign in_hs     = bus.in_valid && in_rdy;
  assign drop_last = (({1'b0, drop_cnt} + 9'd1) == 9'(DROP_N));
  // A restart discards whatever handshakes coincide with it.
  assign push      = (state == RUN) && ks_hs && !start;
  assign pop       = in_hs && !byp && !start;
  assign flush     = start && (state != IDLE);

  assign bus.ks_ready  = ks_rdy;
  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    ks_rdy     = 1'b0;
    in_rdy     = 1'b0;
    case (state)
      IDLE: ;
      WAIT_INIT: begin
        if (gen_init_done) next_state = (DROP_N > 0) ? DROP : RUN;
      end
      DROP: begin
        ks_rdy = 1'b1;
        if (bus.ks_valid && drop_last) next_state = RUN;
      end
      RUN: begin
        ks_rdy = !fifo_full;
        in_rdy = (!fifo_empty || byp) && (!out_valid_q || bus.out_ready);
      end
      default: next_state = IDLE;
    endcase
    if (start) next_state = WAIT_INIT;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt    <= '0;
      word_cnt    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (start) begin
      drop_cnt    <= '0;
      word_cnt    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if ((state == DROP) && ks_hs) drop_cnt <= drop_cnt + 8'd1;
      if (in_hs) begin
        out_data_q  <= byp ? bus.in_data : (bus.in_data ^ fifo_dout);
        out_valid_q <= 1'b1;
        word_cnt    <= word_cnt + CNT_W'(1);
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  ks_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_ks_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (bus.ks_data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

`default_nettype wire

// File: tb/tb_stream_crypt.sv
// ==========================================================================
// tb_stream_crypt: directed self-checking bench, W=8 DEPTH=4 DROP_N=2 CNT_W=4.
// ==========================================================================
`default_nettype none

module tb_stream_crypt;

  logic       clk;
  logic       rst;
  logic       start;
  logic       gen_init_done;
  logic       busy;
  logic [3:0] word_cnt;
  int         checks;
  int         errors;

  stream_crypt_if #(.W(8)) bus ();

  stream_crypt #(
    .W      (8),
    .DEPTH  (4),
    .DROP_N (2),
    .CNT_W  (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .gen_init_done (gen_init_done),
    .bus           (bus),
    .busy          (busy),
    .word_cnt      (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; gen_init_done = 1'b0;
    bus.ks_valid = 1'b0; bus.ks_data = '0; bus.in_valid = 1'b0;
    bus.in_data = '0; bus.out_ready = 1'b0;
`ifdef STREAM_CRYPT_BYPASS_EN
    bus.bypass = 1'b0;
`endif
    tick(); tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", bus.out_data); end
    checks++; if (bus.ks_ready !== 1'b0) begin errors++; $display("FAIL reset_ks_ready got %b want 0", bus.ks_ready); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (word_cnt !== 4'd0) begin errors++; $display("FAIL reset_word_cnt got %0d want 0", word_cnt); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_drop();
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wait_busy got %b want 1", busy); end
    checks++; if (bus.ks_ready !== 1'b0) begin errors++; $display("FAIL wait_ks_ready got %b want 0", bus.ks_ready); end
    gen_init_done = 1'b1; tick();
    checks++; if (bus.ks_ready !== 1'b1) begin errors++; $display("FAIL drop_ks_ready got %b want 1", bus.ks_ready); end
    bus.ks_valid = 1'b1; bus.ks_data = 8'h11; tick();
    bus.ks_data = 8'h22; tick();
    bus.ks_valid = 1'b0;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL drop_nothing_stored got %b want 0", bus.in_ready); end
    bus.ks_valid = 1'b1; bus.ks_data = 8'h3C; tick();
    bus.ks_data = 8'h5A; tick();
    bus.ks_valid = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'hFF;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL drop_in_ready got %b want 1", bus.in_ready); end
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hC3) begin errors++; $display("FAIL drop_out0 got %b/%h want 1/c3", bus.out_valid, bus.out_data); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL drop_stall got %b want 0", bus.in_ready); end
    bus.in_data = 8'h00; tick();
    checks++; if (bus.out_data !== 8'hC3) begin errors++; $display("FAIL drop_hold got %h want c3", bus.out_data); end
    bus.out_ready = 1'b1; tick();
    checks++; if (bus.out_data !== 8'h5A) begin errors++; $display("FAIL drop_out1 got %h want 5a", bus.out_data); end
    checks++; if (word_cnt !== 4'd2) begin errors++; $display("FAIL drop_word_cnt got %0d want 2", word_cnt); end
    bus.in_valid = 1'b0; tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL drop_out_clear got %b want 0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0; bus.ks_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.ks_data = 8'(i + 1);
      checks++; if (bus.ks_ready !== 1'b1) begin errors++; $display("FAIL fill_ks_ready_%0d got %b want 1", i, bus.ks_ready); end
      tick();
    end
    bus.ks_data = 8'h05;
    checks++; if (bus.ks_ready !== 1'b0) begin errors++; $display("FAIL full_ks_ready got %b want 0", bus.ks_ready); end
    bus.in_valid = 1'b1; bus.in_data = 8'h10;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_in_ready got %b want 1", bus.in_ready); end
    tick();
    bus.ks_valid = 1'b0; bus.in_data = 8'h20;
    checks++; if (bus.out_data !== 8'h11) begin errors++; $display("FAIL bp_out0 got %h want 11", bus.out_data); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall0 got %b want 0", bus.in_ready); end
    tick();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall1 got %b want 0", bus.in_ready); end
    bus.out_ready = 1'b1; #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b want 1", bus.in_ready); end
    tick();
    checks++; if (bus.out_data !== 8'h22) begin errors++; $display("FAIL bp_out1 got %h want 22", bus.out_data); end
    bus.in_valid = 1'b0; tick();
  endtask

  task automatic test_restart();
    bus.ks_valid = 1'b1; bus.ks_data = 8'h05; tick(); bus.ks_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (word_cnt !== 4'd0) begin errors++; $display("FAIL restart_word_cnt got %0d want 0", word_cnt); end
    checks++; if (bus.ks_ready !== 1'b0 || bus.in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL restart_wait got ks%b in%b busy%b want 0 0 1", bus.ks_ready, bus.in_ready, busy); end
    tick();
    bus.ks_valid = 1'b1; bus.ks_data = 8'hAA; tick();
    bus.ks_data = 8'hBB; tick();
    bus.ks_valid = 1'b0;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL restart_flushed got %b want 0", bus.in_ready); end
    bus.ks_valid = 1'b1; bus.ks_data = 8'h77; tick(); bus.ks_valid = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'h0F; tick();
    checks++; if (bus.out_data !== 8'h78) begin errors++; $display("FAIL restart_out got %h want 78", bus.out_data); end
    checks++; if (word_cnt !== 4'd1) begin errors++; $display("FAIL restart_cnt got %0d want 1", word_cnt); end
    bus.in_valid = 1'b0; tick();
  endtask

  task automatic test_throughput();
    logic [7:0] ks [4];
    logic [7:0] din [4];
    logic [7:0] exp [4];
    ks  = '{8'h13, 8'h27, 8'h9C, 8'hE1};
    din = '{8'h01, 8'hF0, 8'h55, 8'h3C};
    exp = '{8'h12, 8'hD7, 8'hC9, 8'hDD};
    bus.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.in_data = din[k];
      bus.ks_valid = 1'b1; bus.ks_data = ks[k]; tick(); bus.ks_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL tp_early_%0d got %b want 0", k, bus.out_valid); end
      tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp[k]) begin errors++; $display("FAIL tp_out_%0d got %b/%h want 1/%h", k, bus.out_valid, bus.out_data, exp[k]); end
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL tp_dup_%0d got %b want 0", k, bus.out_valid); end
    end
    bus.in_valid = 1'b0;
    checks++; if (word_cnt !== 4'd5) begin errors++; $display("FAIL tp_word_cnt got %0d want 5", word_cnt); end
  endtask

  task automatic test_back_to_back_wrap();
    logic [7:0] exp;
    start = 1'b1; tick(); start = 1'b0; tick();
    bus.ks_valid = 1'b1; bus.ks_data = 8'hE0; tick();
    bus.ks_data = 8'hE1; tick();
    bus.ks_data = 8'h40; tick();
    for (int j = 1; j <= 17; j++) begin
      bus.ks_data  = 8'(8'h40 + j);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'((j - 1) * 3);
      exp = 8'(8'h40 + j - 1) ^ 8'((j - 1) * 3);
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d got %b want 1", j, bus.in_ready); end
      tick();
      checks++; if (bus.out_data !== exp) begin errors++; $display("FAIL b2b_out_%0d got %h want %h", j, bus.out_data, exp); end
    end
    bus.ks_valid = 1'b0; bus.in_valid = 1'b0;
    checks++; if (word_cnt !== 4'd1) begin errors++; $display("FAIL wrap_word_cnt got %0d want 1", word_cnt); end
    tick();
  endtask

`ifdef STREAM_CRYPT_BYPASS_EN
  task automatic test_bypass();
    bus.bypass = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'hA5; tick();
    checks++; if (bus.out_data !== 8'hA5) begin errors++; $display("FAIL byp_out got %h want a5", bus.out_data); end
    bus.bypass = 1'b0; bus.in_data = 8'h00;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL byp_not_popped got %b want 1", bus.in_ready); end
    tick();
    checks++; if (bus.out_data !== 8'h51) begin errors++; $display("FAIL byp_next_xor got %h want 51", bus.out_data); end
    bus.in_valid = 1'b0; tick();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL byp_empty_plain got %b want 0", bus.in_ready); end
    bus.bypass = 1'b1; #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL byp_empty_bypass got %b want 1", bus.in_ready); end
    bus.bypass = 1'b0;
    checks++; if (word_cnt !== 4'd3) begin errors++; $display("FAIL byp_word_cnt got %0d want 3", word_cnt); end
  endtask
`endif

  task automatic test_async_reset();
    bus.ks_valid = 1'b1; bus.ks_data = 8'h66; tick(); bus.ks_valid = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'h33; tick(); bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.ks_ready !== 1'b1) begin errors++; $display("FAIL pre_rst got v%b k%b want 1 1", bus.out_valid, bus.ks_ready); end
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin errors++; $display("FAIL arst_out got %b/%h want 0/00", bus.out_valid, bus.out_data); end
    checks++; if (bus.in_ready !== 1'b0 || bus.ks_ready !== 1'b0) begin errors++; $display("FAIL arst_ready got in%b ks%b want 0 0", bus.in_ready, bus.ks_ready); end
    checks++; if (busy !== 1'b0 || word_cnt !== 4'd0) begin errors++; $display("FAIL arst_busy_cnt got %b/%0d want 0/0", busy, word_cnt); end
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_drop();
    test_backpressure();
    test_restart();
    test_throughput();
    test_back_to_back_wrap();
`ifdef STREAM_CRYPT_BYPASS_EN
    test_bypass();
`endif
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stream_crypt.md
Name: stream_crypt

Overview:
Parametrised successor to the 7-bit XOR encrypt stage. It sits between a keystream generator (the rc4 core or a wider variant) and the data path. It buffers keystream words in a small FIFO and discards the first DROP_N words (RC4-drop). It then XORs keystream with data under valid/ready handshakes, with a registered output. The same block serves encrypt and decrypt, since XOR is symmetric.

Parameters:
W, 8, data and keystream word width in bits (1..32)
DEPTH, 4, keystream FIFO depth; power of 2, minimum 2
DROP_N, 0, number of initial keystream words discarded after generator init (0..255)
CNT_W, 16, width of the processed-word counter

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  single-cycle pulse; begins a new session
gen_init_done  input  1  keystream generator has finished key scheduling
ks_valid  input  1  keystream word available
ks_data  input  W  keystream word
ks_ready  output  1  block accepts a keystream word this cycle
in_valid  input  1  input data word valid
in_data  input  W  plaintext or ciphertext word
in_ready  output  1  block accepts in_data this cycle
out_valid  output  1  out_data valid
out_data  output  W  in_data XOR keystream
out_ready  input  1  downstream accepts out_data
busy  output  1  state is not IDLE
word_cnt  output  CNT_W  words accepted in the current session; wraps

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, FIFO empty, drop counter=0, word_cnt=0.
  - out_valid=0, out_data=0, ks_ready=0, in_ready=0, busy=0.
- Handshakes: a transfer occurs when valid && ready on the same rising edge. Ready outputs are combinational from state and registers only, never from the same-cycle valid.
- State machine:
  - IDLE: start -> WAIT_INIT.
  - WAIT_INIT: when gen_init_done=1, go to DROP if DROP_N>0, otherwise RUN.
  - DROP: ks_ready=1. Each ks handshake increments the drop counter. The handshake that makes the count equal DROP_N moves to RUN; that word is discarded, not stored.
  - RUN: ks_ready = (fifo_count < DEPTH), evaluated before any same-cycle pop. A ks handshake pushes ks_data.
- start in WAIT_INIT, DROP or RUN (restart) takes priority over every other event that cycle:
  - FIFO flushed, drop counter=0, word_cnt=0, out_valid=0, state=WAIT_INIT.
  - Any pending output word is lost.
  - start in IDLE behaves as above, without the flush.
- Data path (RUN only): in_ready = fifo_not_empty && (!out_valid || out_ready).
  - On an input handshake: out_data <= in_data ^ fifo_head, out_valid <= 1, pop FIFO, word_cnt <= word_cnt+1 (mod 2^CNT_W).
  - Latency: exactly 1 cycle from input handshake to out_valid.
  - Full throughput of 1 word/cycle is sustained while the FIFO is non-empty and out_ready=1.
- out_valid clears on an output handshake with no new input that cycle. out_data holds its value while out_valid && !out_ready.
- Push and pop may occur in the same cycle; fifo_count is then unchanged. A push into a full FIFO never occurs because ks_ready=0.
- Empty FIFO in RUN: in_ready=0 (keystream underrun stalls the data path; no error is raised).
- ks_ready=0 and in_ready=0 in IDLE and WAIT_INIT.

Optional Feature:
STREAM_CRYPT_BYPASS_EN
- Defined: adds input port bypass (1 bit), sampled per input handshake.
  - When bypass=1: out_data <= in_data unmodified, the FIFO is not popped, word_cnt still increments.
  - in_ready in RUN ignores FIFO emptiness for a word presented with bypass=1.
- Undefined: no bypass port; every word is XORed.

Decomposition:
- Package stream_crypt_pkg: state enum (IDLE, WAIT_INIT, DROP, RUN, 2-bit encoding) and the FIFO pointer width function clog2(DEPTH).
- Sub-module ks_fifo (synchronous FIFO, parameters W and DEPTH):
  - ports: push, pop, flush, din, dout, count, full, empty.
  - dout is the head word, available combinationally (first-word fall-through).

Test Plan:
- Reset mid-RUN with out_valid=1: drive rst=0 asynchronously -> out_valid, in_ready and ks_ready are 0 before the next edge; busy=0.
- W=8, DROP_N=2: start, gen_init_done=1, keystream 0x11,0x22,0x3C,0x5A, then in_data 0xFF,0x00 -> out_data 0xC3 then 0x5A; 0x11/0x22 are never used; word_cnt=2.
- DEPTH=4, out_ready held 0, ks_valid held 1: FIFO fills -> ks_ready=0 once 4 words are stored; one input is accepted, then in_ready=0 until out_ready=1.
- Keystream supplied 1 word every 3 cycles, in_valid held 1, out_ready=1 -> out_valid exactly one cycle after each keystream arrival; no word is duplicated or skipped.
- start pulsed in RUN with 3 words buffered -> FIFO empty, word_cnt=0, state WAIT_INIT; the next output uses the first post-drop keystream word of the new session.
- CNT_W=4: accept 17 words -> word_cnt=1 (wrap); with STREAM_CRYPT_BYPASS_EN and bypass=1, in_data=0xA5 -> out_data=0xA5 and fifo_count is unchanged.
